// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART_TX among NUM_REQ byte requesters.
// Captures the winner's byte and parity config, launches the frame, and reports done/timeout per requester.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_par_en,
    input  logic [NUM_REQ-1:0]   req_par_typ,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   done,
    output logic [NUM_REQ-1:0]   err,
    output logic [2:0]           active_id,
    output logic                 arb_busy,
    output logic [7:0]           tx_p_data,
    output logic                 tx_data_valid,
    output logic                 tx_par_en,
    output logic                 tx_par_typ,
    input  logic                 tx_busy
);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_START, WAIT_END} state_t;

    localparam logic [3:0] TIMEOUT = 4'(START_TIMEOUT);
    localparam logic [2:0] LAST_ID = 3'(NUM_REQ - 1);

    state_t               state, state_d;
    logic [2:0]           ptr, ptr_d;
    logic [3:0]           cnt, cnt_d;
    logic [NUM_REQ-1:0]   gnt_d, done_d, err_d;
    logic [2:0]           active_id_d;
    logic                 arb_busy_d;
    logic [7:0]           p_data_d;
    logic                 dv_d, par_en_d, par_typ_d;
    logic [2:0]           winner;
    logic [2:0]           next_ptr;
    logic [NUM_REQ-1:0]   owner_oh;

    // First set request at or after the pointer, searching circularly.
    function automatic logic [2:0] pick(input logic [NUM_REQ-1:0] r, input logic [2:0] p);
        logic [2*NUM_REQ-1:0] dbl;
        logic [3:0]           idx;
        pick = p;
        idx  = '0;
        dbl  = {r, r} >> p;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (dbl[k]) begin
                idx = {1'b0, p} + 4'(k);
                if (idx >= 4'(NUM_REQ)) idx = idx - 4'(NUM_REQ);
                pick = idx[2:0];
            end
        end
    endfunction

    assign winner   = pick(req, ptr);
    assign next_ptr = (active_id == LAST_ID) ? 3'd0 : active_id + 3'd1;

    always_comb begin
        // NOTE: every signal gets a default before the loop so no path leaves it unassigned (no latch).
        owner_oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            owner_oh[i] = (active_id == 3'(i));
        end
    end

    always_comb begin
        state_d     = state;
        ptr_d       = ptr;
        cnt_d       = cnt;
        gnt_d       = '0;
        done_d      = '0;
        err_d       = '0;
        dv_d        = 1'b0;
        active_id_d = active_id;
        arb_busy_d  = arb_busy;
        p_data_d    = tx_p_data;
        par_en_d    = tx_par_en;
        par_typ_d   = tx_par_typ;

        case (state)
            IDLE: begin
                // A busy line means a foreign or leftover frame; wait it out.
                if (req != '0 && !tx_busy) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (winner == 3'(i)) begin
                            gnt_d[i]  = 1'b1;
                            p_data_d  = req_data[8*i +: 8];
                            par_en_d  = req_par_en[i];
                            par_typ_d = req_par_typ[i];
                        end
                    end
                    active_id_d = winner;
                    arb_busy_d  = 1'b1;
                    state_d     = LAUNCH;
                end
            end
            LAUNCH: begin
                dv_d    = 1'b1;
                cnt_d   = '0;
                state_d = WAIT_START;
            end
            WAIT_START: begin
                if (tx_busy) begin
                    state_d = WAIT_END;
                end else if (cnt == TIMEOUT) begin
                    err_d      = owner_oh;
                    arb_busy_d = 1'b0;
                    ptr_d      = next_ptr;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt + 4'd1;
                end
            end
            WAIT_END: begin
                if (!tx_busy) begin
                    done_d     = owner_oh;
                    arb_busy_d = 1'b0;
                    ptr_d      = next_ptr;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            ptr           <= '0;
            cnt           <= '0;
            gnt           <= '0;
            done          <= '0;
            err           <= '0;
            active_id     <= '0;
            arb_busy      <= 1'b0;
            tx_p_data     <= '0;
            tx_data_valid <= 1'b0;
            tx_par_en     <= 1'b0;
            tx_par_typ    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values computed above.
            state         <= state_d;
            ptr           <= ptr_d;
            cnt           <= cnt_d;
            gnt           <= gnt_d;
            done          <= done_d;
            err           <= err_d;
            active_id     <= active_id_d;
            arb_busy      <= arb_busy_d;
            tx_p_data     <= p_data_d;
            tx_data_valid <= dv_d;
            tx_par_en     <= par_en_d;
            tx_par_typ    <= par_typ_d;
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one `UART_TX` serial transmitter among `NUM_REQ` byte requesters. It sits directly in front of `UART_TX` and drives its `P_DATA`, `DATA_VALID`, `PAR_EN` and `PAR_TYP` inputs. It watches `UART_TX.busy` to track each frame from launch to completion, and reports grant, completion and error per requester.

## Interface
- `NUM_REQ`, 4: number of requesters; range 2..8.
- `START_TIMEOUT`, 4: cycles to wait for `TX_BUSY` to rise after launch; range 2..15.
- `CLK` in 1: single clock, shared with `UART_TX`.
- `RST` in 1: reset, asynchronous, active-low.
- `REQ` in NUM_REQ: per-requester send request. Level signal, held until the matching `GNT` bit is seen.
- `REQ_DATA` in 8*NUM_REQ: byte for requester i on bits [8i+7:8i].
- `REQ_PAR_EN` in NUM_REQ: parity enable for requester i.
- `REQ_PAR_TYP` in NUM_REQ: parity type for requester i (0 = even, 1 = odd).
- `GNT` out NUM_REQ: one-hot, 1-cycle pulse. Marks the cycle in which the data and configuration were captured.
- `DONE` out NUM_REQ: one-hot, 1-cycle pulse. The frame for requester i has fully left the line.
- `ERR` out NUM_REQ: one-hot, 1-cycle pulse. Start timeout; the frame was abandoned.
- `ACTIVE_ID` out 3: index of the owning requester. Valid while `ARB_BUSY` = 1.
- `ARB_BUSY` out 1: high from capture until `DONE` or `ERR`.
- `TX_P_DATA` out 8: to `UART_TX.P_DATA`.
- `TX_DATA_VALID` out 1: to `UART_TX.DATA_VALID`.
- `TX_PAR_EN` out 1: to `UART_TX.PAR_EN`.
- `TX_PAR_TYP` out 1: to `UART_TX.PAR_TYP`.
- `TX_BUSY` in 1: from `UART_TX.busy`.

## Operation
- All outputs are registered. Reset value of every output is 0; the round-robin pointer resets to 0.
- State machine: IDLE, LAUNCH, WAIT_START, WAIT_END.
- **IDLE**
  - Condition: `REQ` ≠ 0 and `TX_BUSY` = 0.
  - Selects winner i, the first set `REQ` bit at or after the pointer, modulo NUM_REQ.
  - Latches `REQ_DATA`[i], `REQ_PAR_EN`[i] and `REQ_PAR_TYP`[i] into the `TX_*` registers.
  - Pulses `GNT`[i], sets `ACTIVE_ID` = i and `ARB_BUSY` = 1, then goes to LAUNCH.
  - If `TX_BUSY` = 1 (foreign or leftover frame), stays in IDLE and grants nothing.
- **LAUNCH**
  - `TX_DATA_VALID` = 1 for exactly this one cycle. Clears the timeout counter. Goes to WAIT_START.
- **WAIT_START**
  - `TX_BUSY` = 1: go to WAIT_END.
  - Otherwise the counter increments. When it reaches START_TIMEOUT: pulse `ERR`[i], clear `ARB_BUSY`, set pointer = i+1, go to IDLE.
- **WAIT_END**
  - `TX_BUSY` = 0: pulse `DONE`[i], clear `ARB_BUSY`, set pointer = i+1 (wraps NUM_REQ-1 → 0), go to IDLE.
- `TX_P_DATA`, `TX_PAR_EN` and `TX_PAR_TYP` hold the captured values from capture until the next capture. They never change mid-frame, even if requester inputs change.
- A `REQ` bit dropped before its grant is never granted. `REQ` held after `GNT` is treated as a new request; requesters drop `REQ` on `GNT`.
- Only one grant is issued per frame. New requests are ignored until the FSM returns to IDLE.
- Reset mid-frame: all outputs go to 0 immediately and the FSM returns to IDLE. `UART_TX` shares `RST`, so the line returns to idle with it.

## Timing
- Capture is cycle T. `TX_DATA_VALID` is high in cycle T+1.
- `DONE` is asserted in the cycle after `TX_BUSY` is first sampled low in WAIT_END.
- Earliest next capture is the cycle after `DONE`/`ERR`. Back-to-back frames therefore have at least 2 idle `CLK` cycles between `busy` fall and the next `DATA_VALID`.
- Arbitration is fair: with all `REQ` bits held, grants rotate 0,1,…,NUM_REQ-1,0.
- `ERR` timing: `TX_BUSY` held at 0 makes `ERR` fire START_TIMEOUT+1 cycles after the `TX_DATA_VALID` cycle.

## Test plan
- **Single request.** `REQ`=0001 with `REQ_DATA`[0]=0xA5, PAR_EN=1, PAR_TYP=0 → `GNT`=0001 at T; `TX_DATA_VALID` at T+1 with `TX_P_DATA`=0xA5; `TX_OUT` carries 11 bits with even parity 0; `DONE`=0001 after `busy` falls.
- **Full rotation.** All `REQ` held, data 0x11/0x22/0x33/0x44 → frames 0x11, 0x22, 0x33, 0x44, 0x11 in order; each `DONE` precedes the next `GNT`.
- **Pointer wrap.** Last grant was 3; `REQ`=1001 → next grant is 0, then 3.
- **Config isolation.** Requester 1 uses PAR_EN=0 and requester 2 uses PAR_EN=1, PAR_TYP=1; requester inputs are toggled mid-frame → the frames are 10 and 11 bits with correct odd parity, and `TX_*` stay stable within each frame.
- **Timeout.** `TX_BUSY` tied to 0 → `ERR`[i] pulse 5 cycles after `TX_DATA_VALID` (START_TIMEOUT=4), `ARB_BUSY` clears, and the next requester is served.
- **Reset mid-frame.** `RST` low during data bit 3 → all outputs 0 asynchronously. After release, a pending `REQ`=0100 is granted with the pointer at 0.
